// File: rtl/bnn_digit_classifier.sv
// Binary XNOR-popcount single-layer digit classifier with serial argmax.
// Captures one 196-bit image per image_ready rising edge and reports the winning class as BCD.
module bnn_digit_classifier #(
   parameter int unsigned N_PIX   = 196,
   parameter int unsigned N_CLASS = 10,
   parameter int unsigned CHUNK   = 28,
   parameter int unsigned SCORE_W = 8,
   parameter logic [N_CLASS*N_PIX-1:0] WEIGHTS = '0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [N_PIX-1:0]   image_data,
   input  logic               image_ready,
   output logic               busy,
   output logic               result_valid,
   output logic [3:0]         digit_bcd,
   output logic [SCORE_W-1:0] best_score
);

   localparam int unsigned N_CHK = N_PIX / CHUNK;
   localparam int unsigned CHK_W = (N_CHK > 1) ? $clog2(N_CHK) : 1;
   localparam int unsigned POP_W = $clog2(CHUNK + 1);
   localparam int unsigned CLS_W = 4;

   typedef enum logic [1:0] {IDLE, ACCUM, CMP, DONE} state_t;

   state_t state_q, state_d;

   logic [N_PIX-1:0]   img_q, img_d;
   logic               rdy_q;
   logic [CLS_W-1:0]   cls_q, cls_d, idx_q, idx_d;
   logic [CHK_W-1:0]   chk_q, chk_d;
   logic [SCORE_W-1:0] acc_q, acc_d, best_q, best_d;
   logic               busy_d, valid_d;
   logic [3:0]         digit_d;
   logic [SCORE_W-1:0] score_d;

   logic [N_PIX-1:0]   w_sel, match;
   logic [CHUNK-1:0]   chunk;
   logic [POP_W-1:0]   pop;
   logic               win;

   // Weight row of the current class, agreement mask, and the active chunk's popcount
   always_comb begin
      w_sel = '0;
      for (int k = 0; k < N_CLASS; k++)
         if (cls_q == CLS_W'(k)) w_sel = WEIGHTS[k*N_PIX +: N_PIX];
   end

   assign match = ~(img_q ^ w_sel);

   always_comb begin
      chunk = '0;
      for (int c = 0; c < N_CHK; c++)
         if (chk_q == CHK_W'(c)) chunk = match[c*CHUNK +: CHUNK];
   end

   always_comb begin
      pop = '0;
      for (int i = 0; i < CHUNK; i++) pop = pop + POP_W'(chunk[i]);
   end

   // Strict compare so ties keep the lower class index
   assign win = (cls_q == '0) || (acc_q > best_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      img_d   = img_q;
      cls_d   = cls_q;
      chk_d   = chk_q;
      acc_d   = acc_q;
      best_d  = best_q;
      idx_d   = idx_q;
      busy_d  = busy;
      valid_d = 1'b0;
      digit_d = digit_bcd;
      score_d = best_score;
      case (state_q)
         IDLE: begin
            if (image_ready && !rdy_q) begin
               img_d   = image_data;
               busy_d  = 1'b1;
               cls_d   = '0;
               chk_d   = '0;
               acc_d   = '0;
               state_d = ACCUM;
            end
         end
         ACCUM: begin
            acc_d = acc_q + SCORE_W'(pop);
            if (chk_q == CHK_W'(N_CHK - 1)) state_d = CMP;
            else                            chk_d   = chk_q + CHK_W'(1);
         end
         CMP: begin
            if (win) begin
               best_d = acc_q;
               idx_d  = cls_q;
            end
            if (cls_q == CLS_W'(N_CLASS - 1)) begin
               // Result is published as the FSM enters DONE so it is visible for that cycle
               digit_d = win ? cls_q : idx_q;
               score_d = win ? acc_q : best_q;
               valid_d = 1'b1;
               busy_d  = 1'b0;
               state_d = DONE;
            end else begin
               cls_d   = cls_q + CLS_W'(1);
               chk_d   = '0;
               acc_d   = '0;
               state_d = ACCUM;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         img_q        <= '0;
         rdy_q        <= 1'b0;
         cls_q        <= '0;
         chk_q        <= '0;
         acc_q        <= '0;
         best_q       <= '0;
         idx_q        <= '0;
         busy         <= 1'b0;
         result_valid <= 1'b0;
         digit_bcd    <= '0;
         best_score   <= '0;
      end else begin
         img_q        <= img_d;
         rdy_q        <= image_ready;
         cls_q        <= cls_d;
         chk_q        <= chk_d;
         acc_q        <= acc_d;
         best_q       <= best_d;
         idx_q        <= idx_d;
         busy         <= busy_d;
         result_valid <= valid_d;
         digit_bcd    <= digit_d;
         best_score   <= score_d;
      end
   end

endmodule

// File: tb/tb_bnn_digit_classifier.sv
// Scoreboard bench for bnn_digit_classifier: one instance with all-zero weights, one with crafted weights.
module tb_bnn_digit_classifier;

   localparam int unsigned NP  = 196;
   localparam int unsigned NC  = 10;
   localparam int unsigned LAT = 81;

   // Class k = A ^ mask_k; class 7 is A itself, classes 3/5 differ in disjoint 46-bit blocks
   function automatic logic [NC*NP-1:0] make_weights();
      logic [NC*NP-1:0] w;
      logic [NP-1:0]    a, m;
      a = {7{28'hA5C396E}};
      w = '0;
      for (int k = 0; k < NC; k++) begin
         m = '0;
         for (int i = 0; i < NP; i++) begin
            if (k == 3 && i < 46) m[i] = 1'b1;
            else if (k == 5 && i >= 46 && i < 92) m[i] = 1'b1;
            else if (k != 3 && k != 5 && k != 7 && i >= 92 && i < 92 + 8*k + 4) m[i] = 1'b1;
         end
         w[k*NP +: NP] = a ^ m;
      end
      return w;
   endfunction

   localparam logic [NC*NP-1:0] W_CRAFT = make_weights();
   localparam logic [NC*NP-1:0] W_ZERO  = '0;

   typedef struct {
      logic [3:0]  d;
      logic [7:0]  s;
      int unsigned c;
   } exp_t;

   logic          clk, rst_n, image_ready;
   logic [NP-1:0] image_data;
   logic          busy_z, rv_z, busy_w, rv_w;
   logic [3:0]    digit_z, digit_w;
   logic [7:0]    score_z, score_w;

   int unsigned cyc;
   int          checks, errors;
   exp_t        q0[$], q1[$];
   logic [3:0]  last_d[2];
   logic [7:0]  last_s[2];

   bnn_digit_classifier #(.WEIGHTS(W_ZERO)) dut_z (
      .clk(clk), .rst_n(rst_n), .image_data(image_data), .image_ready(image_ready),
      .busy(busy_z), .result_valid(rv_z), .digit_bcd(digit_z), .best_score(score_z));

   bnn_digit_classifier #(.WEIGHTS(W_CRAFT)) dut_w (
      .clk(clk), .rst_n(rst_n), .image_data(image_data), .image_ready(image_ready),
      .busy(busy_w), .result_valid(rv_w), .digit_bcd(digit_w), .best_score(score_w));

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: score every class by XNOR agreement count, first maximum wins
   function automatic void model(input logic [NC*NP-1:0] w, input logic [NP-1:0] img,
                                 output logic [3:0] d, output logic [7:0] s);
      int best, sc;
      best = -1;
      d = 0;
      for (int k = 0; k < NC; k++) begin
         sc = $countones(~(img ^ w[k*NP +: NP]));
         if (sc > best) begin
            best = sc;
            d = 4'(k);
         end
      end
      s = 8'(best);
   endfunction

   task automatic start_img(input logic [NP-1:0] img);
      exp_t e;
      image_data  = img;
      image_ready = 1'b1;
      e.c = cyc;
      model(W_ZERO, img, e.d, e.s);
      q0.push_back(e);
      model(W_CRAFT, img, e.d, e.s);
      q1.push_back(e);
   endtask

   task automatic wait_result();
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!rv_w && n < 200);
      if (!rv_w) chk("result_timeout", 0, 1);
   endtask

   task automatic mon(input int i, input logic rv, input logic bz,
                      input logic [3:0] d, input logic [7:0] s);
      exp_t e;
      int   sz;
      sz = (i == 0) ? q0.size() : q1.size();
      if (rv) begin
         if (sz == 0) begin
            chk($sformatf("unexpected_result_%0d", i), sz, 1);
         end else begin
            e = (i == 0) ? q0.pop_front() : q1.pop_front();
            chk($sformatf("digit_%0d", i), int'(d), int'(e.d));
            chk($sformatf("score_%0d", i), int'(s), int'(e.s));
            chk($sformatf("latency_%0d", i), int'(cyc - e.c), int'(LAT));
            chk($sformatf("busy_at_result_%0d", i), int'(bz), 0);
            last_d[i] = e.d;
            last_s[i] = e.s;
         end
      end else begin
         chk($sformatf("digit_hold_%0d", i), int'(d), int'(last_d[i]));
         chk($sformatf("score_hold_%0d", i), int'(s), int'(last_s[i]));
      end
   endtask

   always @(negedge clk) begin
      if (!rst_n) begin
         last_d = '{default: '0};
         last_s = '{default: '0};
      end else begin
         mon(0, rv_z, busy_z, digit_z, score_z);
         mon(1, rv_w, busy_w, digit_w, score_w);
      end
   end

   task automatic check_zero(input string tag);
      chk({tag, "_busy"}, int'(busy_z) + int'(busy_w), 0);
      chk({tag, "_valid"}, int'(rv_z) + int'(rv_w), 0);
      chk({tag, "_digit"}, int'(digit_z) + int'(digit_w), 0);
      chk({tag, "_score"}, int'(score_z) + int'(score_w), 0);
   endtask

   logic [NP-1:0] img, a_pat;
   int            k;

   initial begin
      checks = 0;
      errors = 0;
      cyc = 0;
      a_pat = {7{28'hA5C396E}};
      last_d = '{default: '0};
      last_s = '{default: '0};
      rst_n = 1'b0;
      image_ready = 1'b0;
      image_data = '0;
      repeat (3) @(negedge clk);
      check_zero("reset");
      rst_n = 1'b1;
      repeat (200) @(negedge clk);
      check_zero("idle200");

      // All-zero image: full tie on the zero-weight instance
      start_img('0);
      @(negedge clk);
      chk("busy_after_start", int'(busy_z) + int'(busy_w), 2);
      wait_result();
      image_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("busy_idle_t2", int'(busy_w), 0);

      // Exact match with class 7
      start_img(a_pat);
      wait_result();
      image_ready = 1'b0;
      repeat (2) @(negedge clk);
      chk("busy_idle_t3", int'(busy_w), 0);
      chk("digit_t3", int'(digit_w), 7);

      // Classes 3 and 5 tie at 150
      img = a_pat;
      for (int i = 0; i < 92; i++) img[i] = ~img[i];
      start_img(img);
      wait_result();
      image_ready = 1'b0;
      @(negedge clk);
      chk("digit_t4", int'(digit_w), 3);
      chk("score_t4", int'(score_w), 150);

      // Level held high with a toggle and a data change mid-compute
      @(negedge clk);
      img = W_CRAFT[4*NP +: NP];
      img[5] = ~img[5];
      start_img(img);
      for (int t = 1; t < 300; t++) begin
         @(negedge clk);
         if (t == 10) image_data = ~image_data;
         if (t == 40) image_ready = 1'b0;
         if (t == 41) image_ready = 1'b1;
      end
      image_ready = 1'b0;
      @(negedge clk);
      chk("pending_t5", q0.size() + q1.size(), 0);

      // Reset mid-compute aborts the result
      @(negedge clk);
      start_img(W_CRAFT[6*NP +: NP]);
      repeat (30) @(negedge clk);
      image_ready = 1'b0;
      rst_n = 1'b0;
      #1;
      check_zero("abort");
      q0.delete();
      q1.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      start_img(W_CRAFT[2*NP +: NP]);
      wait_result();
      image_ready = 1'b0;
      @(negedge clk);
      chk("digit_t6", int'(digit_w), 2);

      // Randomised back-to-back stream; each start lands in the cycle after DONE
      for (int n = 0; n < 24; n++) begin
         k = $urandom_range(0, NC - 1);
         if ($urandom_range(0, 3) == 0) begin
            for (int i = 0; i < NP; i++) img[i] = 1'($urandom_range(0, 1));
         end else begin
            img = W_CRAFT[k*NP +: NP];
            repeat ($urandom_range(0, 70)) begin
               k = $urandom_range(0, NP - 1);
               img[k] = ~img[k];
            end
         end
         start_img(img);
         wait_result();
         image_ready = 1'b0;
         @(negedge clk);
      end

      repeat (120) @(negedge clk);
      chk("queue_drained", q0.size() + q1.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
